pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB). It combines the ID-stage load-use bubble request, I-cache and D-cache handshakes, and MEM-stage branch resolution. From these it drives per-register load enables, NOP-flush strobes and the PC redirect. A branch resolved while a fetch is outstanding is remembered, with its target latched, until the fetch completes.

---
 rtl/pipeline_stall_controller.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline: merges load-use, I/D-cache and branch-redirect requests.
// Optional STALL_PERF_EN adds four 32-bit stall/flush performance counters.
module pipeline_stall_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use_hazard,
  input  logic        imem_req,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        load_pc,
  output logic        pc_sel,
  output logic [15:0] redirect_target,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_dstall,
  output logic [31:0] perf_istall,
  output logic [31:0] perf_load_use,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic {RUN, REDIRECT_WAIT} state_t;

  state_t      state, state_next;
  logic [15:0] target_q;
  logic        dstall, istall, capture, redirect_req;

  assign dstall       = dmem_req & ~dmem_resp;
  assign istall       = imem_req & ~imem_resp;
  assign redirect_req = rst_n & (((state == RUN) & br_taken) | (state == REDIRECT_WAIT));
  assign capture      = rst_n & (state == RUN) & br_taken & ~dstall;

  // The redirect is combinational on br_taken, so the incoming target bypasses the latch.
  assign redirect_target = capture ? br_target : target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      target_q <= 16'h0000;
    end else begin
      state <= state_next;
      if (capture) target_q <= br_target;
    end
  end

  always_comb begin
    state_next   = state;
    load_pc      = 1'b0;
    pc_sel       = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (!rst_n || dstall) begin
      state_next = state;
    end else if (redirect_req) begin
      // A redirect squashes any pending load-use bubble; the doomed fetch is discarded on its response.
      load_id_ex   = 1'b1;
      flush_id_ex  = 1'b1;
      load_ex_mem  = 1'b1;
      flush_ex_mem = 1'b1;
      load_mem_wb  = 1'b1;
      if (istall) begin
        state_next = REDIRECT_WAIT;
      end else begin
        load_pc     = 1'b1;
        pc_sel      = 1'b1;
        load_if_id  = 1'b1;
        flush_if_id = 1'b1;
        state_next  = RUN;
      end
    end else if (istall || load_use_hazard) begin
      load_id_ex  = 1'b1;
      flush_id_ex = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end else begin
      load_pc     = 1'b1;
      load_if_id  = 1'b1;
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_dstall   <= 32'd0;
      perf_istall   <= 32'd0;
      perf_load_use <= 32'd0;
      perf_flush    <= 32'd0;
    end else begin
      if (dstall) perf_dstall <= perf_dstall + 32'd1;
      if (istall && !dstall) perf_istall <= perf_istall + 32'd1;
      if (!dstall && !redirect_req && load_use_hazard) perf_load_use <= perf_load_use + 32'd1;
      if (!dstall && redirect_req && load_pc) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

  // Both conditions indicate an upstream bug rather than something this block can resolve.
  a_br_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == REDIRECT_WAIT) && br_taken));
  a_br_with_dmem: assert property (@(posedge clk) disable iff (!rst_n)
    !(br_taken && dmem_req));

endmodule
